// File: rtl/multicycle_ctrl.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
//  Module      : multicycle_ctrl
//  Description : Control FSM for a multicycle RV32-style datapath. Sequences
//                FETCH/DECODE/EXEC/MEM/WB, decodes ALU operations, drives
//                memory handshakes, traps on unknown opcodes and counts
//                retired instructions.
//  Revision    : 1.0  initial release
// ============================================================================
module multicycle_ctrl #(
    parameter int WIDTH  = 32,
    parameter int ALU_OP = 4
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [6:0]        opcode,
    input  logic [2:0]        funct3,
    input  logic              funct7_5,
    input  logic              alu_zero,
    input  logic              mem_ready,
    output logic              mem_req,
    output logic              mem_we,
    output logic              ir_we,
    output logic              pc_we,
    output logic              reg_we,
    output logic              addr_sel,
    output logic              alu_src_a,
    output logic              alu_src_b,
    output logic              pc_sel,
    output logic [1:0]        wb_sel,
    output logic [ALU_OP-1:0] alu_op,
    output logic [2:0]        state,
    output logic              illegal,
    output logic              retire,
    output logic [WIDTH-1:0]  instret
);

    typedef enum logic [2:0] {
        S_FETCH  = 3'd0,
        S_DECODE = 3'd1,
        S_EXEC   = 3'd2,
        S_MEM    = 3'd3,
        S_WB     = 3'd4,
        S_TRAP   = 3'd5
    } state_t;

    localparam logic [6:0] c_OP_R   = 7'b0110011;
    localparam logic [6:0] c_OP_I   = 7'b0010011;
    localparam logic [6:0] c_OP_LD  = 7'b0000011;
    localparam logic [6:0] c_OP_ST  = 7'b0100011;
    localparam logic [6:0] c_OP_BR  = 7'b1100011;
    localparam logic [6:0] c_OP_JAL = 7'b1101111;

    localparam logic [ALU_OP-1:0] c_ALU_ADD = ALU_OP'(0);
    localparam logic [ALU_OP-1:0] c_ALU_SUB = ALU_OP'(1);
    localparam logic [ALU_OP-1:0] c_ALU_AND = ALU_OP'(2);
    localparam logic [ALU_OP-1:0] c_ALU_OR  = ALU_OP'(3);
    localparam logic [ALU_OP-1:0] c_ALU_XOR = ALU_OP'(4);
    localparam logic [ALU_OP-1:0] c_ALU_SLT = ALU_OP'(5);
    localparam logic [ALU_OP-1:0] c_ALU_SLL = ALU_OP'(6);
    localparam logic [ALU_OP-1:0] c_ALU_SRL = ALU_OP'(7);
    localparam logic [ALU_OP-1:0] c_ALU_SRA = ALU_OP'(8);

    localparam logic [WIDTH-1:0] c_INSTRET_ONE = {{(WIDTH-1){1'b0}}, 1'b1};

    state_t           r_state;
    state_t           w_next;
    logic             r_illegal;
    logic [WIDTH-1:0] r_instret;

    logic w_is_r, w_is_i, w_is_ld, w_is_st, w_is_br, w_is_jal, w_known;
    logic w_taken;
    logic [ALU_OP-1:0] w_alu_fn;

    assign w_is_r   = (opcode == c_OP_R);
    assign w_is_i   = (opcode == c_OP_I);
    assign w_is_ld  = (opcode == c_OP_LD);
    assign w_is_st  = (opcode == c_OP_ST);
    assign w_is_br  = (opcode == c_OP_BR);
    assign w_is_jal = (opcode == c_OP_JAL);
    assign w_known  = w_is_r | w_is_i | w_is_ld | w_is_st | w_is_br | w_is_jal;

    // Only BEQ and BNE are supported; every other branch funct3 falls through.
    assign w_taken = ((funct3 == 3'b000) &&  alu_zero) ||
                     ((funct3 == 3'b001) && !alu_zero);

    // ALU function for R/I arithmetic; funct7_5 selects SUB only for R-type.
    always_comb begin
        w_alu_fn = c_ALU_ADD;
        case (funct3)
            3'b000:  w_alu_fn = (w_is_r && funct7_5) ? c_ALU_SUB : c_ALU_ADD;
            3'b111:  w_alu_fn = c_ALU_AND;
            3'b110:  w_alu_fn = c_ALU_OR;
            3'b100:  w_alu_fn = c_ALU_XOR;
            3'b010:  w_alu_fn = c_ALU_SLT;
            3'b001:  w_alu_fn = c_ALU_SLL;
            3'b101:  w_alu_fn = funct7_5 ? c_ALU_SRA : c_ALU_SRL;
            default: w_alu_fn = c_ALU_ADD;
        endcase
    end

    // Next-state and datapath strobe decode; everything forced idle in reset.
    always_comb begin
        w_next    = r_state;
        mem_req   = 1'b0;
        mem_we    = 1'b0;
        ir_we     = 1'b0;
        pc_we     = 1'b0;
        reg_we    = 1'b0;
        addr_sel  = 1'b0;
        alu_src_a = 1'b0;
        alu_src_b = 1'b0;
        pc_sel    = 1'b0;
        wb_sel    = 2'b00;
        alu_op    = c_ALU_ADD;
        retire    = 1'b0;
        case (r_state)
            S_FETCH: begin
                mem_req = 1'b1;
                if (mem_ready) begin
                    ir_we  = 1'b1;
                    pc_we  = 1'b1;
                    w_next = S_DECODE;
                end
            end
            S_DECODE: begin
                w_next = w_known ? S_EXEC : S_TRAP;
            end
            S_EXEC: begin
                if (w_is_r) begin
                    alu_op = w_alu_fn;
                    w_next = S_WB;
                end else if (w_is_i) begin
                    alu_src_b = 1'b1;
                    alu_op    = w_alu_fn;
                    w_next    = S_WB;
                end else if (w_is_ld || w_is_st) begin
                    alu_src_b = 1'b1;
                    w_next    = S_MEM;
                end else if (w_is_br) begin
                    alu_op = c_ALU_SUB;
                    if (w_taken) begin
                        pc_we  = 1'b1;
                        pc_sel = 1'b1;
                    end
                    w_next = S_FETCH;
                end else if (w_is_jal) begin
                    alu_src_a = 1'b1;
                    alu_src_b = 1'b1;
                    pc_we     = 1'b1;
                    pc_sel    = 1'b1;
                    w_next    = S_WB;
                end else begin
                    // Instruction register changed under us after DECODE.
                    w_next = S_TRAP;
                end
            end
            S_MEM: begin
                mem_req  = 1'b1;
                addr_sel = 1'b1;
                mem_we   = w_is_st;
                if (mem_ready) begin
                    w_next = w_is_st ? S_FETCH : S_WB;
                end
            end
            S_WB: begin
                reg_we = 1'b1;
                if (w_is_ld) begin
                    wb_sel = 2'b01;
                end else if (w_is_jal) begin
                    wb_sel = 2'b10;
                end
                w_next = S_FETCH;
            end
            S_TRAP: begin
                w_next = S_TRAP;
            end
            default: begin
                w_next = S_FETCH;
            end
        endcase

        retire = (w_next == S_FETCH) && (r_state inside {S_EXEC, S_MEM, S_WB});

        // Reset must kill an in-flight handshake without waiting for a clock.
        if (!rst_n) begin
            mem_req   = 1'b0;
            mem_we    = 1'b0;
            ir_we     = 1'b0;
            pc_we     = 1'b0;
            reg_we    = 1'b0;
            addr_sel  = 1'b0;
            alu_src_a = 1'b0;
            alu_src_b = 1'b0;
            pc_sel    = 1'b0;
            wb_sel    = 2'b00;
            alu_op    = c_ALU_ADD;
            retire    = 1'b0;
        end
    end

    // State register, sticky trap flag and retired-instruction counter.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state   <= S_FETCH;
            r_illegal <= 1'b0;
            r_instret <= '0;
        end else begin
            r_state   <= w_next;
            r_illegal <= (w_next == S_TRAP);
            if (retire) begin
                r_instret <= r_instret + c_INSTRET_ONE;
            end
        end
    end

    assign state   = r_state;
    assign illegal = r_illegal;
    assign instret = r_instret;

endmodule
`default_nettype wire

// File: tb/tb_multicycle_ctrl.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
//  Module      : tb_multicycle_ctrl
//  Description : Scoreboard bench for multicycle_ctrl. Stimulus pushes the
//                hand-computed per-instruction expectations; a monitor pops
//                and compares them each time the DUT retires.
//  Revision    : 1.0  initial release
// ============================================================================
module tb_multicycle_ctrl;

    // Narrow counter so the wrap-around is reachable in a short run.
    localparam int W = 8;

    localparam logic [2:0] S_FETCH = 3'd0;
    localparam logic [2:0] S_EXEC  = 3'd2;
    localparam logic [2:0] S_MEM   = 3'd3;
    localparam logic [2:0] S_TRAP  = 3'd5;

    localparam logic [6:0] OP_R   = 7'b0110011;
    localparam logic [6:0] OP_I   = 7'b0010011;
    localparam logic [6:0] OP_LD  = 7'b0000011;
    localparam logic [6:0] OP_ST  = 7'b0100011;
    localparam logic [6:0] OP_BR  = 7'b1100011;
    localparam logic [6:0] OP_JAL = 7'b1101111;

    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic [6:0]   opcode = '0;
    logic [2:0]   funct3 = '0;
    logic         funct7_5 = 1'b0;
    logic         alu_zero = 1'b0;
    logic         mem_ready = 1'b0;
    logic         mem_req, mem_we, ir_we, pc_we, reg_we;
    logic         addr_sel, alu_src_a, alu_src_b, pc_sel;
    logic [1:0]   wb_sel;
    logic [3:0]   alu_op;
    logic [2:0]   state;
    logic         illegal, retire;
    logic [W-1:0] instret;

    always #5 clk = ~clk;

    multicycle_ctrl #(.WIDTH(W), .ALU_OP(4)) dut (
        .clk(clk), .rst_n(rst_n), .opcode(opcode), .funct3(funct3),
        .funct7_5(funct7_5), .alu_zero(alu_zero), .mem_ready(mem_ready),
        .mem_req(mem_req), .mem_we(mem_we), .ir_we(ir_we), .pc_we(pc_we),
        .reg_we(reg_we), .addr_sel(addr_sel), .alu_src_a(alu_src_a),
        .alu_src_b(alu_src_b), .pc_sel(pc_sel), .wb_sel(wb_sel),
        .alu_op(alu_op), .state(state), .illegal(illegal), .retire(retire),
        .instret(instret)
    );

    typedef struct {
        int           lat;
        int           regwe_n;
        logic [1:0]   wbsel;
        logic         pcwe;
        logic [3:0]   aluop;
        logic         srca;
        logic         srcb;
        int           freq;
        int           mreq;
        logic         mwe;
        logic [W-1:0] ir;
    } exp_t;

    exp_t sb_q[$];
    int   n_checks  = 0;
    int   n_pass    = 0;
    int   n_retired = 0;

    function automatic exp_t mk(input int lat, input int regwe_n, input logic [1:0] wbsel,
                                input logic pcwe, input logic [3:0] aluop, input logic srca,
                                input logic srcb, input int freq, input int mreq,
                                input logic mwe, input logic [W-1:0] ir);
        exp_t e;
        e.lat = lat; e.regwe_n = regwe_n; e.wbsel = wbsel; e.pcwe = pcwe;
        e.aluop = aluop; e.srca = srca; e.srcb = srcb; e.freq = freq;
        e.mreq = mreq; e.mwe = mwe; e.ir = ir;
        return e;
    endfunction

    task automatic chk(input string name, input longint act, input longint exp);
        n_checks++;
        if (act == exp) n_pass++;
        else $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
    endtask

    // Memory responder: ready after fetch_wait/mem_wait wait cycles, noise otherwise.
    int fetch_wait = 0, mem_wait = 0, wait_cnt = 0;
    always @(negedge clk) begin
        if (!rst_n) begin
            wait_cnt  = 0;
            mem_ready = 1'b0;
        end else if (mem_req) begin
            if (wait_cnt >= ((state == S_FETCH) ? fetch_wait : mem_wait)) begin
                mem_ready = 1'b1;
                wait_cnt  = 0;
            end else begin
                mem_ready = 1'b0;
                wait_cnt++;
            end
        end else begin
            mem_ready = 1'($urandom_range(0, 1));
        end
    end

    // Monitor: accumulate per-instruction observations, compare on retire.
    int           cyc, regwe_n, freq, mreq, irwe_n, fpcwe_n;
    logic [1:0]   s_wbsel;
    logic         s_pcwe, s_pcsel, s_srca, s_srcb, s_mwe, s_addr_bad;
    logic [3:0]   s_aluop;
    logic         pend = 1'b0;
    logic [W-1:0] pend_val;
    exp_t         e_pop;

    task automatic clear_obs();
        cyc = 0; regwe_n = 0; freq = 0; mreq = 0; irwe_n = 0; fpcwe_n = 0;
        s_wbsel = 2'b00; s_pcwe = 1'b0; s_pcsel = 1'b0; s_srca = 1'b0;
        s_srcb = 1'b0; s_mwe = 1'b0; s_addr_bad = 1'b0; s_aluop = 4'd0;
    endtask

    initial clear_obs();

    always begin
        @(negedge clk);
        #2;
        if (pend) begin
            chk("instret", instret, pend_val);
            pend = 1'b0;
        end
        if (!rst_n) begin
            clear_obs();
        end else begin
            cyc++;
            if (state == S_FETCH && mem_req) freq++;
            if (state == S_MEM && mem_req) mreq++;
            if (state == S_FETCH && addr_sel) s_addr_bad = 1'b1;
            if (state == S_MEM && !addr_sel) s_addr_bad = 1'b1;
            if (ir_we) irwe_n++;
            if (state == S_FETCH && pc_we && !pc_sel) fpcwe_n++;
            if (mem_we) s_mwe = 1'b1;
            if (reg_we) begin
                regwe_n++;
                s_wbsel = wb_sel;
            end
            if (state == S_EXEC) begin
                s_aluop = alu_op; s_pcwe = pc_we; s_pcsel = pc_sel;
                s_srca = alu_src_a; s_srcb = alu_src_b;
            end
            if (retire) begin
                if (sb_q.size() == 0) begin
                    chk("unexpected_retire", 1, 0);
                end else begin
                    e_pop = sb_q.pop_front();
                    chk("latency", cyc, e_pop.lat);
                    chk("reg_we_cycles", regwe_n, e_pop.regwe_n);
                    chk("wb_sel", s_wbsel, e_pop.wbsel);
                    chk("exec_pc_we", s_pcwe, e_pop.pcwe);
                    chk("exec_pc_sel", s_pcsel, e_pop.pcwe);
                    chk("exec_alu_op", s_aluop, e_pop.aluop);
                    chk("exec_alu_src_a", s_srca, e_pop.srca);
                    chk("exec_alu_src_b", s_srcb, e_pop.srcb);
                    chk("fetch_req_cycles", freq, e_pop.freq);
                    chk("mem_req_cycles", mreq, e_pop.mreq);
                    chk("mem_we", s_mwe, e_pop.mwe);
                    chk("addr_sel_bad", s_addr_bad, 0);
                    chk("ir_we_cycles", irwe_n, 1);
                    chk("fetch_pc_we_cycles", fpcwe_n, 1);
                    pend     = 1'b1;
                    pend_val = e_pop.ir;
                end
                n_retired++;
                clear_obs();
            end
        end
    end

    // Issue one instruction from FETCH and wait (bounded) for it to retire.
    task automatic issue(input logic [6:0] op, input logic [2:0] f3, input logic f75,
                         input logic z, input int fw, input int mw, input exp_t e);
        int target;
        opcode = op; funct3 = f3; funct7_5 = f75; alu_zero = z;
        fetch_wait = fw; mem_wait = mw;
        sb_q.push_back(e);
        target = n_retired + 1;
        for (int i = 0; i < 60 && n_retired < target; i++) begin
            @(negedge clk);
            #3;
        end
        chk("retire_seen", (n_retired >= target) ? 1 : 0, 1);
        @(posedge clk);
        #1;
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        repeat (2) @(posedge clk);
        #1;
        chk("rst_state", state, 0);
        chk("rst_mem_req", mem_req, 0);
        chk("rst_illegal", illegal, 0);
        chk("rst_instret", instret, 0);
        rst_n = 1'b1;
        #1;
        chk("post_rst_mem_req", mem_req, 1);

        //     op      f3    f75   z     fw mw     lat rw wbsel pcwe alu   sa    sb    fq mq mwe   instret
        issue(OP_R,   3'd0, 1'b0, 1'b0, 0, 0, mk(4,  1, 2'd0, 1'b0, 4'd0, 1'b0, 1'b0, 1, 0, 1'b0, 8'd1));
        issue(OP_R,   3'd0, 1'b1, 1'b0, 0, 0, mk(4,  1, 2'd0, 1'b0, 4'd1, 1'b0, 1'b0, 1, 0, 1'b0, 8'd2));
        issue(OP_I,   3'd0, 1'b1, 1'b0, 0, 0, mk(4,  1, 2'd0, 1'b0, 4'd0, 1'b0, 1'b1, 1, 0, 1'b0, 8'd3));
        issue(OP_I,   3'd5, 1'b1, 1'b0, 0, 0, mk(4,  1, 2'd0, 1'b0, 4'd8, 1'b0, 1'b1, 1, 0, 1'b0, 8'd4));
        issue(OP_R,   3'd7, 1'b0, 1'b0, 0, 0, mk(4,  1, 2'd0, 1'b0, 4'd2, 1'b0, 1'b0, 1, 0, 1'b0, 8'd5));
        issue(OP_I,   3'd6, 1'b0, 1'b0, 0, 0, mk(4,  1, 2'd0, 1'b0, 4'd3, 1'b0, 1'b1, 1, 0, 1'b0, 8'd6));
        issue(OP_R,   3'd4, 1'b0, 1'b0, 0, 0, mk(4,  1, 2'd0, 1'b0, 4'd4, 1'b0, 1'b0, 1, 0, 1'b0, 8'd7));
        issue(OP_R,   3'd2, 1'b0, 1'b0, 0, 0, mk(4,  1, 2'd0, 1'b0, 4'd5, 1'b0, 1'b0, 1, 0, 1'b0, 8'd8));
        issue(OP_I,   3'd1, 1'b0, 1'b0, 0, 0, mk(4,  1, 2'd0, 1'b0, 4'd6, 1'b0, 1'b1, 1, 0, 1'b0, 8'd9));
        issue(OP_R,   3'd5, 1'b0, 1'b0, 0, 0, mk(4,  1, 2'd0, 1'b0, 4'd7, 1'b0, 1'b0, 1, 0, 1'b0, 8'd10));
        issue(OP_LD,  3'd2, 1'b0, 1'b0, 3, 3, mk(11, 1, 2'd1, 1'b0, 4'd0, 1'b0, 1'b1, 4, 4, 1'b0, 8'd11));
        issue(OP_ST,  3'd2, 1'b0, 1'b0, 0, 0, mk(4,  0, 2'd0, 1'b0, 4'd0, 1'b0, 1'b1, 1, 1, 1'b1, 8'd12));
        issue(OP_BR,  3'd1, 1'b0, 1'b0, 0, 0, mk(3,  0, 2'd0, 1'b1, 4'd1, 1'b0, 1'b0, 1, 0, 1'b0, 8'd13));
        issue(OP_BR,  3'd1, 1'b0, 1'b1, 0, 0, mk(3,  0, 2'd0, 1'b0, 4'd1, 1'b0, 1'b0, 1, 0, 1'b0, 8'd14));
        issue(OP_BR,  3'd0, 1'b0, 1'b1, 0, 0, mk(3,  0, 2'd0, 1'b1, 4'd1, 1'b0, 1'b0, 1, 0, 1'b0, 8'd15));
        issue(OP_BR,  3'd0, 1'b0, 1'b0, 0, 0, mk(3,  0, 2'd0, 1'b0, 4'd1, 1'b0, 1'b0, 1, 0, 1'b0, 8'd16));
        issue(OP_BR,  3'd4, 1'b0, 1'b1, 0, 0, mk(3,  0, 2'd0, 1'b0, 4'd1, 1'b0, 1'b0, 1, 0, 1'b0, 8'd17));
        issue(OP_JAL, 3'd0, 1'b0, 1'b0, 0, 0, mk(4,  1, 2'd2, 1'b1, 4'd0, 1'b1, 1'b1, 1, 0, 1'b0, 8'd18));
        issue(OP_ST,  3'd2, 1'b0, 1'b0, 2, 1, mk(7,  0, 2'd0, 1'b0, 4'd0, 1'b0, 1'b1, 3, 2, 1'b1, 8'd19));

        // Unknown opcode: trap and stay quiet under random mem_ready.
        opcode = 7'b0000000; funct3 = 3'd0; funct7_5 = 1'b0; fetch_wait = 0;
        for (int i = 0; i < 10 && state != S_TRAP; i++) begin
            @(negedge clk);
            #3;
        end
        chk("trap_state", state, S_TRAP);
        chk("trap_illegal", illegal, 1);
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            #3;
            chk("trap_strobes", {mem_req, mem_we, ir_we, pc_we, reg_we, retire}, 0);
            chk("trap_hold", state, S_TRAP);
            chk("trap_instret", instret, 19);
        end

        @(posedge clk);
        #3;
        rst_n = 1'b0;
        #1;
        chk("trap_rst_state", state, S_FETCH);
        chk("trap_rst_illegal", illegal, 0);
        chk("trap_rst_instret", instret, 0);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        #1;

        issue(OP_R, 3'd0, 1'b0, 1'b0, 0, 0, mk(4, 1, 2'd0, 1'b0, 4'd0, 1'b0, 1'b0, 1, 0, 1'b0, 8'd1));

        // Store stalled in MEM, then reset asynchronously mid-handshake.
        opcode = OP_ST; funct3 = 3'd2; fetch_wait = 0; mem_wait = 1000;
        for (int i = 0; i < 10 && state != S_MEM; i++) begin
            @(negedge clk);
            #3;
        end
        @(posedge clk);
        #3;
        chk("stall_state", state, S_MEM);
        chk("stall_mem_req", mem_req, 1);
        chk("stall_mem_we", mem_we, 1);
        rst_n = 1'b0;
        #1;
        chk("async_rst_mem_req", mem_req, 0);
        chk("async_rst_mem_we", mem_we, 0);
        chk("async_rst_state", state, S_FETCH);
        chk("async_rst_instret", instret, 0);
        @(posedge clk);
        #3;
        mem_wait = 0;
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        #1;
        chk("release_state", state, S_FETCH);
        chk("release_instret", instret, 0);
        chk("release_mem_req", mem_req, 1);

        // Back-to-back not-taken BEQs up to all-ones, then wrap to zero.
        for (int k = 1; k <= 255; k++) begin
            issue(OP_BR, 3'd0, 1'b0, 1'b0, 0, 0,
                  mk(3, 0, 2'd0, 1'b0, 4'd1, 1'b0, 1'b0, 1, 0, 1'b0, W'(k)));
        end
        chk("pre_wrap_instret", instret, 255);
        issue(OP_BR, 3'd0, 1'b0, 1'b0, 0, 0, mk(3, 0, 2'd0, 1'b0, 4'd1, 1'b0, 1'b0, 1, 0, 1'b0, 8'd0));
        repeat (2) @(negedge clk);
        #3;
        chk("scoreboard_empty", sb_q.size(), 0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/multicycle_ctrl.md
MULTICYCLE_CTRL -- requirements
Module: multicycle_ctrl

Interface
REQ-001 SHALL have parameter: WIDTH, 32, datapath width and width of the retired-instruction counter.
REQ-002 SHALL have parameter: ALU_OP, 4, width of alu_op.
REQ-003 SHALL have port: clk  input  1  single clock; all state changes on its rising edge.
REQ-004 SHALL have port: rst_n  input  1  asynchronous, active-low reset.
REQ-005 SHALL have port: opcode  input  7  instruction[6:0] from the datapath instruction register.
REQ-006 SHALL have port: funct3  input  3  instruction[14:12].
REQ-007 SHALL have port: funct7_5  input  1  instruction[30].
REQ-008 SHALL have port: alu_zero  input  1  ALU result equals zero.
REQ-009 SHALL have port: mem_ready  input  1  memory handshake completion.
REQ-010 SHALL have ports: mem_req, mem_we, ir_we, pc_we, reg_we  output  1 each  datapath strobes.
REQ-011 SHALL have ports: addr_sel (0=PC, 1=ALU), alu_src_a (0=rs1, 1=old_pc), alu_src_b (0=rs2, 1=imm)  output  1 each.
REQ-012 SHALL have ports: pc_sel (0=PC+4, 1=ALU target)  output  1; wb_sel (00=ALU, 01=mem data, 10=old_pc+4)  output  2.
REQ-013 SHALL have port: alu_op  output  ALU_OP  0=ADD, 1=SUB, 2=AND, 3=OR, 4=XOR, 5=SLT, 6=SLL, 7=SRL, 8=SRA.
REQ-014 SHALL have ports: state  output  3; illegal  output  1; retire  output  1; instret  output  WIDTH.

Function
REQ-015 SHALL implement states FETCH=0, DECODE=1, EXEC=2, MEM=3, WB=4, TRAP=5; codes 6-7 SHALL return to FETCH.
REQ-016 Outputs other than instret and illegal SHALL decode combinationally from state and the instruction fields; inactive strobes are 0 and selects default to 0.
REQ-017 FETCH: mem_req=1, addr_sel=0; on mem_ready: ir_we=1, pc_we=1, pc_sel=0, next DECODE; otherwise remain in FETCH.
REQ-018 Handshake: mem_req SHALL stay high until mem_ready is sampled high; mem_ready SHALL be ignored while mem_req=0; mem_ready high in the first request cycle (zero wait) SHALL be accepted.
REQ-019 DECODE: no strobes; opcode in {0110011, 0010011, 0000011, 0100011, 1100011, 1101111} -> EXEC; any other opcode -> TRAP.
REQ-020 EXEC for R-type: alu_src_b=0; alu_op from funct3 (000 ADD, or SUB if funct7_5=1; 111 AND; 110 OR; 100 XOR; 010 SLT; 001 SLL; 101 SRL, or SRA if funct7_5=1); next WB.
REQ-021 EXEC for I-type ALU: alu_src_b=1; same mapping, except funct3=000 always ADD; next WB.
REQ-022 EXEC for load/store: alu_src_b=1, alu_op=ADD; next MEM.
REQ-023 EXEC for branch: alu_src_b=0, alu_op=SUB. Taken = (funct3=000 and alu_zero) or (funct3=001 and !alu_zero). If taken: pc_we=1, pc_sel=1. Any other funct3 is not-taken. Next FETCH.
REQ-024 EXEC for JAL: alu_src_a=1, alu_src_b=1, alu_op=ADD, pc_we=1, pc_sel=1; next WB.
REQ-025 MEM: mem_req=1, addr_sel=1, mem_we=1 for store and 0 for load; hold until mem_ready; then load -> WB, store -> FETCH.
REQ-026 WB: reg_we=1 for exactly one cycle; wb_sel=01 for load, 10 for JAL, 00 otherwise; next FETCH.
REQ-027 retire SHALL pulse for one cycle on every transition into FETCH from EXEC, MEM or WB; instret SHALL increment by 1 on the following edge and wrap from all-ones to 0.
REQ-028 TRAP: illegal=1, all strobes 0, state held until reset; mem_ready SHALL be ignored.
REQ-029 Instruction latency in cycles, with zero-wait memory: R/I/JAL 4, branch 3, store 4, load 5; each wait cycle adds one cycle.

Reset
REQ-030 rst_n low SHALL immediately force state=FETCH, illegal=0, instret=0, and all strobes to 0, including mid-handshake; mem_req SHALL reassert from the first clock after deassertion.

Verification
REQ-031 add (opcode 0110011, funct3 000, funct7_5 0), zero-wait memory -> FETCH, DECODE, EXEC(alu_op 0), WB(reg_we 1, wb_sel 00), FETCH; retire once; instret 0->1.
REQ-032 lw with mem_ready delayed 3 cycles in both FETCH and MEM -> mem_req held 4 cycles in each; 11 cycles total; wb_sel=01 in WB.
REQ-033 bne (funct3 001), alu_zero=0 -> pc_we=1, pc_sel=1 in EXEC; with alu_zero=1 -> pc_we=0; 3 cycles, no WB.
REQ-034 opcode 0000000 -> TRAP, illegal=1; random mem_ready for 20 cycles -> no strobe and no instret change.
REQ-035 rst_n pulsed low during MEM wait of a store -> mem_we and mem_req drop asynchronously; after release, state=FETCH and instret=0.
REQ-036 instret preloaded by 2^32-1 back-to-back retirements -> next retire wraps instret to 0.
